// File: rtl/mcu_batch_core.sv
// mcu_batch_core
//   Small compute-and-log engine. A command (start) either runs one ALU
//   operation on two W-bit operands and appends the 2W-bit result to an
//   internal result store (mode 0), or reads back one stored slot (mode 1).
//   Every command takes the same number of cycles from start to done.
//
// Parameters
//   W      operand width (>=4, power of 2); results are 2*W bits
//   DEPTH  number of result-store entries (power of 2)
//   WRAP   1: write pointer wraps when full, oldest entry overwritten
//          0: writes rejected when full (err pulse with done)
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   start     command strobe, only looked at while idle
//   mode      0 = compute+store, 1 = read back
//   in1, in2  W-bit unsigned operands
//   sel       ALU opcode (0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 MUL, 7 SHL)
//   rd_addr   slot to read back in mode 1
//   busy      high whenever a command is in flight
//   done      one-cycle completion pulse
//   err       one-cycle pulse alongside done when a store write was rejected
//   out_data  last ALU result (mode 0) or slot contents (mode 1), held until next done
//   wr_ptr    next slot to be written
//   count     number of valid entries, saturates at DEPTH
module mcu_batch_core #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int WRAP  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       mode,
    input  logic [W-1:0]               in1,
    input  logic [W-1:0]               in2,
    input  logic [2:0]                 sel,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [2*W-1:0]             out_data,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(W);

    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW:0]   CNT_DEPTH = DEPTH;
    localparam logic          WRAP_EN   = (WRAP != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    // Unsigned ALU; every result is zero-extended to 2W bits.
    function automatic logic [2*W-1:0] alu(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [2:0]   op);
        logic [W:0]     s;
        logic [2*W-1:0] r;
        s = '0;
        r = '0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};   // bit W is the carry
                r = {{(W-1){1'b0}}, s};
            end
            3'd1: begin
                s = {1'b0, a} - {1'b0, b};   // bit W is the borrow
                r = {{(W-1){1'b0}}, s};
            end
            3'd2: r = {{W{1'b0}}, a & b};
            3'd3: r = {{W{1'b0}}, a | b};
            3'd4: r = {{W{1'b0}}, a ^ b};
            3'd5: r = {{W{1'b0}}, ~a};
            3'd6: r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            3'd7: r = {{W{1'b0}}, a} << b[SW-1:0];
        endcase
        return r;
    endfunction

    state_t           state_q;
    logic [W-1:0]     in1_q;
    logic [W-1:0]     in2_q;
    logic [2:0]       sel_q;
    logic             mode_q;
    logic [AW-1:0]    rd_addr_q;
    logic [2*W-1:0]   result_q;
    logic [2*W-1:0]   out_data_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW:0]      count_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [2*W-1:0]   mem_q [DEPTH];

    logic [2*W-1:0]   result_d;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW:0]      count_d;
    logic             wr_ok;
    logic             wr_en;

    always_comb begin
        result_d = alu(in1_q, in2_q, sel_q);
        wr_ok    = (count_q < CNT_DEPTH) || WRAP_EN;
        wr_en    = (state_q == S_WRITE) && wr_ok && !reset;
        // DEPTH is a power of two, so the pointer wraps by plain overflow.
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        count_d  = (count_q == CNT_DEPTH) ? count_q : count_q + CNT_ONE;
    end

    // Result store: contents survive reset; gated by reset so an aborted
    // command never lands in the store.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            in1_q      <= '0;
            in2_q      <= '0;
            sel_q      <= '0;
            mode_q     <= 1'b0;
            rd_addr_q  <= '0;
            result_q   <= '0;
            out_data_q <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        in1_q     <= in1;
                        in2_q     <= in2;
                        sel_q     <= sel;
                        mode_q    <= mode;
                        rd_addr_q <= rd_addr;
                        busy_q    <= 1'b1;
                        state_q   <= S_LOAD;
                    end
                end
                // Read-back also passes through EXEC so both modes share
                // the same start-to-done latency; the ALU result is unused then.
                S_LOAD: state_q <= S_EXEC;
                S_EXEC: begin
                    result_q <= result_d;
                    state_q  <= mode_q ? S_READ : S_WRITE;
                end
                S_WRITE: begin
                    if (wr_ok) begin
                        wr_ptr_q <= wr_ptr_d;
                        count_q  <= count_d;
                    end
                    // The result is reported even when the store rejects it.
                    out_data_q <= result_q;
                    err_q      <= !wr_ok;
                    done_q     <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_READ: begin
                    out_data_q <= mem_q[rd_addr_q];
                    done_q     <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign out_data = out_data_q;
    assign wr_ptr   = wr_ptr_q;
    assign count    = count_q;

endmodule

// File: tb/tb_mcu_batch_core.sv
module tb_mcu_batch_core;

    logic        clk;
    logic        reset;
    logic        start;
    logic        mode;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic [2:0]  sel;
    logic [1:0]  rd_addr;

    logic        busy0, done0, err0;
    logic [15:0] out0;
    logic [1:0]  ptr0;
    logic [2:0]  cnt0;

    logic        busy1, done1, err1;
    logic [15:0] out1;
    logic [1:0]  ptr1;
    logic [2:0]  cnt1;

    mcu_batch_core #(.W(8), .DEPTH(4), .WRAP(0)) u0 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .in1(in1), .in2(in2), .sel(sel), .rd_addr(rd_addr),
        .busy(busy0), .done(done0), .err(err0), .out_data(out0),
        .wr_ptr(ptr0), .count(cnt0)
    );

    mcu_batch_core #(.W(8), .DEPTH(4), .WRAP(1)) u1 (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .in1(in1), .in2(in2), .sel(sel), .rd_addr(rd_addr),
        .busy(busy1), .done(done1), .err(err1), .out_data(out1),
        .wr_ptr(ptr1), .count(cnt1)
    );

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic [1:0]  ptr;
        logic [2:0]  cnt;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0m, e1m;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] d0, input logic e0, input logic [1:0] p0,
                        input logic [2:0] c0, input logic [15:0] d1, input logic e1,
                        input logic [1:0] p1, input logic [2:0] c1, input int dcyc);
        exp_t x;
        x.data = d0; x.err = e0; x.ptr = p0; x.cnt = c0; x.cyc = dcyc;
        q0.push_back(x);
        x.data = d1; x.err = e1; x.ptr = p1; x.cnt = c1; x.cyc = dcyc;
        q1.push_back(x);
    endtask

    // One command; operands are scrambled right after acceptance so the
    // expected results also prove the DUT latched them at start.
    task automatic run(input logic m, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] s, input logic [1:0] ra,
                       input logic [15:0] d0, input logic e0, input logic [1:0] p0, input logic [2:0] c0,
                       input logic [15:0] d1, input logic e1, input logic [1:0] p1, input logic [2:0] c1);
        int acc;
        @(negedge clk);
        mode = m; in1 = a; in2 = b; sel = s; rd_addr = ra; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = cyc;
        mode = ~m; in1 = ~a; in2 = ~b; sel = ~s; rd_addr = ~ra;
        push(d0, e0, p0, c0, d1, e1, p1, c1, acc + 3);
        repeat (3) @(negedge clk);
    endtask

    // Scoreboard monitor: every done pops one expected response.
    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL u0_unexpected_done: got done=1 out=%0h expected no pending command", out0);
            end else begin
                e0m = q0.pop_front();
                chk("u0_out_data", {16'h0, out0}, {16'h0, e0m.data});
                chk("u0_err", {31'h0, err0}, {31'h0, e0m.err});
                chk("u0_wr_ptr", {30'h0, ptr0}, {30'h0, e0m.ptr});
                chk("u0_count", {29'h0, cnt0}, {29'h0, e0m.cnt});
                chk("u0_done_cycle", cyc, e0m.cyc);
            end
        end
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL u1_unexpected_done: got done=1 out=%0h expected no pending command", out1);
            end else begin
                e1m = q1.pop_front();
                chk("u1_out_data", {16'h0, out1}, {16'h0, e1m.data});
                chk("u1_err", {31'h0, err1}, {31'h0, e1m.err});
                chk("u1_wr_ptr", {30'h0, ptr1}, {30'h0, e1m.ptr});
                chk("u1_count", {29'h0, cnt1}, {29'h0, e1m.cnt});
                chk("u1_done_cycle", cyc, e1m.cyc);
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        in1 = '0; in2 = '0; sel = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy0", {31'h0, busy0}, 0);
        chk("rst_done0", {31'h0, done0}, 0);
        chk("rst_err0", {31'h0, err0}, 0);
        chk("rst_out0", {16'h0, out0}, 0);
        chk("rst_ptr0", {30'h0, ptr0}, 0);
        chk("rst_cnt0", {29'h0, cnt0}, 0);
        chk("rst_busy1", {31'h0, busy1}, 0);
        chk("rst_done1", {31'h0, done1}, 0);
        chk("rst_out1", {16'h0, out1}, 0);
        chk("rst_cnt1", {29'h0, cnt1}, 0);
        reset = 1'b0;

        // Fill the 4-entry store, then one write beyond full.
        run(0, 8'hFF, 8'h01, 3'd0, 2'd0, 16'h0100, 0, 2'd1, 3'd1, 16'h0100, 0, 2'd1, 3'd1);
        run(0, 8'hFF, 8'hFF, 3'd6, 2'd0, 16'hFE01, 0, 2'd2, 3'd2, 16'hFE01, 0, 2'd2, 3'd2);
        run(0, 8'h01, 8'h02, 3'd1, 2'd0, 16'h01FF, 0, 2'd3, 3'd3, 16'h01FF, 0, 2'd3, 3'd3);
        run(0, 8'h81, 8'h03, 3'd7, 2'd0, 16'h0408, 0, 2'd0, 3'd4, 16'h0408, 0, 2'd0, 3'd4);
        run(0, 8'hF0, 8'h3C, 3'd2, 2'd0, 16'h0030, 1, 2'd0, 3'd4, 16'h0030, 0, 2'd1, 3'd4);
        // Read back: slot 0 kept (reject) vs overwritten (wrap); slot 3 common.
        run(1, 8'h00, 8'h00, 3'd0, 2'd0, 16'h0100, 0, 2'd0, 3'd4, 16'h0030, 0, 2'd1, 3'd4);
        run(1, 8'h00, 8'h00, 3'd0, 2'd3, 16'h0408, 0, 2'd0, 3'd4, 16'h0408, 0, 2'd1, 3'd4);

        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst2_ptr0", {30'h0, ptr0}, 0);
        chk("rst2_cnt1", {29'h0, cnt1}, 0);
        reset = 1'b0;

        run(0, 8'h0F, 8'hA0, 3'd3, 2'd0, 16'h00AF, 0, 2'd1, 3'd1, 16'h00AF, 0, 2'd1, 3'd1);

        // Reset while the command sits in EXEC: aborted, no done, no write.
        @(negedge clk);
        mode = 1'b0; in1 = 8'h5A; in2 = 8'hFF; sel = 3'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy0", {31'h0, busy0}, 0);
        chk("abort_ptr0", {30'h0, ptr0}, 0);
        chk("abort_cnt0", {29'h0, cnt0}, 0);
        chk("abort_done0", {31'h0, done0}, 0);
        chk("abort_busy1", {31'h0, busy1}, 0);
        chk("abort_cnt1", {29'h0, cnt1}, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        run(0, 8'h5A, 8'hFF, 3'd4, 2'd0, 16'h00A5, 0, 2'd1, 3'd1, 16'h00A5, 0, 2'd1, 3'd1);
        run(0, 8'h3C, 8'h00, 3'd5, 2'd0, 16'h00C3, 0, 2'd2, 3'd2, 16'h00C3, 0, 2'd2, 3'd2);
        run(0, 8'h7F, 8'h01, 3'd0, 2'd0, 16'h0080, 0, 2'd3, 3'd3, 16'h0080, 0, 2'd3, 3'd3);

        // Start pulse while busy must be ignored: exactly one done.
        @(negedge clk);
        mode = 1'b1; rd_addr = 2'd1; sel = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc_m = cyc;
        push(16'h00C3, 0, 2'd3, 3'd3, 16'h00C3, 0, 2'd3, 3'd3, acc_m + 3);
        @(negedge clk);
        chk("busy_mid_cmd0", {31'h0, busy0}, 1);
        mode = 1'b0; in1 = 8'hFF; in2 = 8'hFF; sel = 3'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // start held high: a new command accepted every 5 cycles.
        @(negedge clk);
        mode = 1'b1; rd_addr = 2'd2; sel = 3'd0; start = 1'b1;
        acc_m = cyc + 1;
        push(16'h0080, 0, 2'd3, 3'd3, 16'h0080, 0, 2'd3, 3'd3, acc_m + 3);
        push(16'h0080, 0, 2'd3, 3'd3, 16'h0080, 0, 2'd3, 3'd3, acc_m + 8);
        push(16'h0080, 0, 2'd3, 3'd3, 16'h0080, 0, 2'd3, 3'd3, acc_m + 13);
        repeat (12) @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);

        chk("u0_pending_left", q0.size(), 0);
        chk("u1_pending_left", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
